// File: rtl/digtal_frame_sync_if.sv
// Byte-stream bundle for digtal_frame_sync: the received byte strobe in, the framed payload strobe out.
// The master is the byte source and payload sink. The slave is the framer.
interface digtal_frame_sync_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       frame_start;
    logic       frame_end;

    modport master (
        output byte_valid, byte_data,
        input  out_valid, out_data, frame_start, frame_end
    );

    modport slave (
        input  byte_valid, byte_data,
        output out_valid, out_data, frame_start, frame_end
    );
endinterface

// File: rtl/digtal_frame_sync.sv
// Frame synchroniser: hunts for the sync word, verifies it over frames and locks with a miss flywheel.
// Define DIGTAL_SYNC_CHECKSUM_EN to check the last payload byte as the modulo-256 sum of the payload.
module digtal_frame_sync #(
    parameter int          SYNC_LENGTH  = 4,
    parameter logic [63:0] SYNC_WORD    = 64'hEB9090EB,
    parameter int          FRAME_LENGTH = 2048,
    parameter int          VERIFY_COUNT = 2,
    parameter int          MISS_LIMIT   = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    digtal_frame_sync_if.slave  bus,
    output logic                o_locked,
    output logic                o_sync_miss,
    output logic [7:0]          o_slip_cnt,
    output logic                o_chk_err
);
    localparam int SW = 8 * SYNC_LENGTH;
    localparam int PW = $clog2(FRAME_LENGTH);
    localparam int HW = $clog2(VERIFY_COUNT + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [SW-1:0] SYNC_PAT  = SYNC_WORD[SW-1:0];
    localparam logic [PW-1:0] CHK_POS   = PW'(SYNC_LENGTH - 1);
    localparam logic [PW-1:0] FIRST_POS = PW'(SYNC_LENGTH);
    localparam logic [PW-1:0] LAST_POS  = PW'(FRAME_LENGTH - 1);
    localparam logic [HW-1:0] HIT_GOAL  = HW'(VERIFY_COUNT);
    localparam logic [MW-1:0] MISS_GOAL = MW'(MISS_LIMIT);

    typedef enum logic [1:0] {ST_HUNT, ST_CHECK, ST_LOCK} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-9:0] r_hist;
    logic [SW-1:0] w_window;
    logic [PW-1:0] r_pos;
    logic [HW-1:0] r_hits;
    logic [MW-1:0] r_misses;
    logic          w_match;
    logic          w_chk_pt;
    logic          w_hit_done;
    logic          w_miss_done;
    logic          w_enter_lock;
    logic          w_slip;
    logic          w_out_valid;
    logic          w_frame_start;
    logic          w_frame_end;
    logic          w_sync_miss;
    logic          r_out_valid;
    logic [7:0]    r_out_data;
    logic          r_frame_start;
    logic          r_frame_end;
    logic          r_sync_miss;
    logic [7:0]    r_slip_cnt;

    // Only the previous SYNC_LENGTH-1 bytes are stored; the current byte completes the window.
    assign w_window    = {r_hist, bus.byte_data};
    assign w_match     = (w_window == SYNC_PAT);
    assign w_chk_pt    = bus.byte_valid && (r_pos == CHK_POS);
    assign w_hit_done  = ((r_hits + HW'(1)) == HIT_GOAL);
    assign w_miss_done = ((r_misses + MW'(1)) == MISS_GOAL);

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) r_state <= ST_HUNT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        w_state_nxt = r_state;
        if (bus.byte_valid) begin
            unique case (r_state)
                ST_HUNT:  if (w_match) w_state_nxt = (VERIFY_COUNT == 1) ? ST_LOCK : ST_CHECK;
                ST_CHECK: if (w_chk_pt) w_state_nxt = !w_match ? ST_HUNT : (w_hit_done ? ST_LOCK : ST_CHECK);
                ST_LOCK:  if (w_chk_pt && !w_match && w_miss_done) w_state_nxt = ST_HUNT;
                default:  w_state_nxt = ST_HUNT;
            endcase
        end
    end

    // State only changes at the check point, so gating on the current state keeps frames whole.
    always_comb begin
        w_out_valid   = bus.byte_valid && (r_state == ST_LOCK) && (r_pos >= FIRST_POS);
        w_frame_start = w_out_valid && (r_pos == FIRST_POS);
        w_frame_end   = w_out_valid && (r_pos == LAST_POS);
        w_sync_miss   = (r_state == ST_LOCK) && w_chk_pt && !w_match;
        w_enter_lock  = (r_state != ST_LOCK) && (w_state_nxt == ST_LOCK);
        w_slip        = (r_state == ST_LOCK) && (w_state_nxt == ST_HUNT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist   <= '0;
            r_pos    <= '0;
            r_hits   <= '0;
            r_misses <= '0;
        end else if (bus.byte_valid) begin
            r_hist <= w_window[SW-9:0];
            if (r_state == ST_HUNT && w_match) r_pos <= FIRST_POS;
            else if (r_pos == LAST_POS)        r_pos <= '0;
            else                               r_pos <= r_pos + PW'(1);
            if (r_state == ST_HUNT && w_match)                      r_hits <= HW'(1);
            else if (r_state == ST_CHECK && w_chk_pt && w_match)    r_hits <= r_hits + HW'(1);
            if (w_enter_lock)                        r_misses <= '0;
            else if (r_state == ST_LOCK && w_chk_pt) r_misses <= w_match ? '0 : r_misses + MW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_sync_miss   <= 1'b0;
            r_slip_cnt    <= '0;
        end else begin
            r_out_valid   <= w_out_valid;
            r_out_data    <= w_out_valid ? bus.byte_data : 8'h00;
            r_frame_start <= w_frame_start;
            r_frame_end   <= w_frame_end;
            r_sync_miss   <= w_sync_miss;
            if (w_slip && r_slip_cnt != 8'hFF) r_slip_cnt <= r_slip_cnt + 8'd1;
        end
    end

`ifdef DIGTAL_SYNC_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_chk_err;

    // The sum restarts on the first payload byte and excludes the checksum byte itself.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum     <= '0;
            r_chk_err <= 1'b0;
        end else begin
            r_chk_err <= w_frame_end && (bus.byte_data != r_sum);
            if (bus.byte_valid) begin
                if (r_pos == FIRST_POS)     r_sum <= bus.byte_data;
                else if (r_pos != LAST_POS) r_sum <= r_sum + bus.byte_data;
            end
        end
    end

    assign o_chk_err = r_chk_err;
`else
    assign o_chk_err = 1'b0;
`endif

    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_end   = r_frame_end;
    assign o_locked        = (r_state == ST_LOCK);
    assign o_sync_miss     = r_sync_miss;
    assign o_slip_cnt      = r_slip_cnt;
endmodule
